// File: rtl/pc_fetch_unit.sv
// Fetch front end: holds the PC, issues instruction-memory reads and delivers
// fetched words to decode. Redirects from execute retarget the PC. A redirect
// that arrives while a read is outstanding is queued until that read completes.
module pc_fetch_unit #(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam logic [ADDR_W-1:0] PcInc = ADDR_W'(4);

  typedef enum logic [0:0] {StFetch, StDeliver} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              pend_valid_q;
  logic [ADDR_W-1:0] pend_pc_q;
  logic              req_q;
  logic              valid_q;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] pc_out_q;
  logic [ADDR_W-1:0] pc_plus4_q;

  logic [ADDR_W-1:0] redir_tgt;
  logic [ADDR_W-1:0] ack_tgt;
  logic              redir_hit;

  // Word-align the target; a same-cycle redirect overrides a queued one.
  always_comb begin
    redir_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};
    ack_tgt   = redirect_valid ? redir_tgt : pend_pc_q;
    redir_hit = redirect_valid | pend_valid_q;
  end

  // Fetch/deliver FSM with all outputs registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
      req_q        <= 1'b0;
      valid_q      <= 1'b0;
      instr_q      <= '0;
      pc_out_q     <= RESET_PC;
      pc_plus4_q   <= RESET_PC + PcInc;
    end else begin
      case (state_q)
        StFetch: begin
          if (!req_q) begin
            // Idle cycle (after reset or a discarded fetch): nothing is in
            // flight, so a redirect can retarget the PC directly.
            req_q <= 1'b1;
            if (redirect_valid) pc_q <= redir_tgt;
          end else if (imem_ack) begin
            req_q <= 1'b0;
            if (redir_hit) begin
              // Wrong-path data: drop it and refetch from the target.
              pc_q         <= ack_tgt;
              pend_valid_q <= 1'b0;
            end else begin
              instr_q    <= imem_rdata;
              pc_out_q   <= pc_q;
              pc_plus4_q <= pc_q + PcInc;
              valid_q    <= 1'b1;
              state_q    <= StDeliver;
            end
          end else if (redirect_valid) begin
            // Address must stay stable until ack, so queue the target.
            pend_valid_q <= 1'b1;
            pend_pc_q    <= redir_tgt;
          end
        end
        StDeliver: begin
          if (redirect_valid) begin
            // Consumed or killed, either way the next fetch is the target.
            pc_q    <= redir_tgt;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= StFetch;
          end else if (instr_ready) begin
            pc_q    <= pc_q + PcInc;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= StFetch;
          end
        end
        default: state_q <= StFetch;
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign pc_plus4    = pc_plus4_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit. Instance a runs the scripted scenario;
// instance b uses a high reset PC with an always-ack memory to cover PC wrap.
module tb_pc_fetch_unit;

  logic        clock;
  logic        reset_n;

  logic        a_req, a_ack, a_valid, ready, redir_v;
  logic [31:0] a_addr, a_rdata, a_instr, a_pc, a_p4, redir_pc;
  logic        auto_ack, man_ack;

  logic        b_req, b_valid;
  logic [31:0] b_addr, b_rdata, b_instr, b_pc, b_p4;

  int n_vec;
  int n_err;

  // Memory stubs: data word is a fixed function of the address.
  assign a_ack   = (auto_ack & a_req) | man_ack;
  assign a_rdata = a_addr ^ 32'hDEAD_0000;
  assign b_rdata = b_addr ^ 32'hDEAD_0000;

  pc_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut_a (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_req       (a_req),
    .imem_addr      (a_addr),
    .imem_ack       (a_ack),
    .imem_rdata     (a_rdata),
    .instr_valid    (a_valid),
    .instr_ready    (ready),
    .instr_out      (a_instr),
    .pc_out         (a_pc),
    .pc_plus4       (a_p4),
    .redirect_valid (redir_v),
    .redirect_pc    (redir_pc)
  );

  pc_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_req       (b_req),
    .imem_addr      (b_addr),
    .imem_ack       (b_req),
    .imem_rdata     (b_rdata),
    .instr_valid    (b_valid),
    .instr_ready    (1'b1),
    .instr_out      (b_instr),
    .pc_out         (b_pc),
    .pc_plus4       (b_p4),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] ea, eb;
    n_vec = 0; n_err = 0;
    reset_n = 1'b0; auto_ack = 1'b1; man_ack = 1'b0;
    ready = 1'b1; redir_v = 1'b0; redir_pc = '0;
    #12;
    chk("rst_req",    32'(a_req),   32'h0);
    chk("rst_valid",  32'(a_valid), 32'h0);
    chk("rst_instr",  a_instr,      32'h0);
    chk("rst_pc_out", a_pc,         32'h0);
    chk("rst_plus4",  a_p4,         32'h4);
    chk("rst_b_pc",   b_pc,         32'hFFFF_FFF8);
    chk("rst_b_p4",   b_p4,         32'hFFFF_FFFC);
    chk("rst_b_req",  32'(b_req),   32'h0);
    reset_n = 1'b1;
    tick();

    // Streaming with immediate ack: one instruction every two cycles.
    for (int i = 0; i < 4; i++) begin
      ea = 32'(4 * i);
      eb = 32'hFFFF_FFF8 + 32'(4 * i);
      chk("seq_req",   32'(a_req),   32'h1);
      chk("seq_addr",  a_addr,       ea);
      chk("seq_vlo",   32'(a_valid), 32'h0);
      if (i < 3) chk("wrap_addr", b_addr, eb);
      tick();
      chk("seq_vhi",   32'(a_valid), 32'h1);
      chk("seq_pc",    a_pc,         ea);
      chk("seq_p4",    a_p4,         ea + 32'h4);
      chk("seq_instr", a_instr,      ea ^ 32'hDEAD_0000);
      chk("seq_reqlo", 32'(a_req),   32'h0);
      if (i < 3) begin
        chk("wrap_pc", b_pc, eb);
        chk("wrap_p4", b_p4, eb + 32'h4);
      end
      if (i == 3) auto_ack = 1'b0;
      tick();
    end

    // Delayed ack at 0x10 with a redirect during the wait.
    ready = 1'b0;
    chk("dly_req",  32'(a_req), 32'h1);
    chk("dly_addr", a_addr,     32'h10);
    tick();
    redir_v = 1'b1; redir_pc = 32'h103;
    tick();
    redir_v = 1'b0;
    chk("dly_hold2", a_addr,       32'h10);
    chk("dly_req2",  32'(a_req),   32'h1);
    chk("dly_v2",    32'(a_valid), 32'h0);
    tick();
    chk("dly_hold3", a_addr, 32'h10);
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    chk("dly_drop_req", 32'(a_req),   32'h0);
    chk("dly_drop_v",   32'(a_valid), 32'h0);
    chk("dly_newpc",    a_addr,       32'h100);
    tick();
    chk("dly_rereq",  32'(a_req), 32'h1);
    chk("dly_readdr", a_addr,     32'h100);

    // Get to 0x20, then stall decode while holding it.
    redir_v = 1'b1; redir_pc = 32'h20; man_ack = 1'b1;
    tick();
    redir_v = 1'b0; man_ack = 1'b0;
    chk("hold_gap", 32'(a_req), 32'h0);
    tick();
    chk("hold_addr", a_addr, 32'h20);
    man_ack = 1'b1;
    tick();
    // Ack stays high while req is low; it must be ignored.
    for (int k = 0; k < 5; k++) begin
      chk("hold_v",     32'(a_valid), 32'h1);
      chk("hold_pc",    a_pc,         32'h20);
      chk("hold_instr", a_instr,      32'h20 ^ 32'hDEAD_0000);
      chk("hold_noreq", 32'(a_req),   32'h0);
      if (k < 4) tick();
    end
    man_ack = 1'b0;
    ready = 1'b1; redir_v = 1'b1; redir_pc = 32'h400;
    tick();
    ready = 1'b0; redir_v = 1'b0;
    chk("cons_redir_req",  32'(a_req),   32'h1);
    chk("cons_redir_addr", a_addr,       32'h400);
    chk("cons_redir_v",    32'(a_valid), 32'h0);

    // Two redirects during one wait: last one wins.
    redir_v = 1'b1; redir_pc = 32'h200;
    tick();
    redir_v = 1'b0;
    tick();
    redir_v = 1'b1; redir_pc = 32'h300;
    tick();
    redir_v = 1'b0;
    chk("two_hold", a_addr, 32'h400);
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    chk("two_drop_v", 32'(a_valid), 32'h0);
    chk("two_newpc",  a_addr,       32'h300);
    tick();
    chk("two_req", 32'(a_req), 32'h1);
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    chk("two_v",     32'(a_valid), 32'h1);
    chk("two_pc",    a_pc,         32'h300);
    chk("two_p4",    a_p4,         32'h304);
    chk("two_instr", a_instr,      32'h300 ^ 32'hDEAD_0000);

    // Reset pulse during a fetch wait, with a stale ack across release.
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("rp_addr", a_addr, 32'h304);
    chk("rp_v",    32'(a_valid), 32'h0);
    tick();
    #3;
    reset_n = 1'b0;
    #1;
    chk("rp_async_req", 32'(a_req),   32'h0);
    chk("rp_async_v",   32'(a_valid), 32'h0);
    chk("rp_async_pc",  a_addr,       32'h0);
    man_ack = 1'b1;
    tick();
    #2;
    reset_n = 1'b1;
    tick();
    man_ack = 1'b0;
    chk("rp_req",   32'(a_req),   32'h1);
    chk("rp_addr0", a_addr,       32'h0);
    chk("rp_stale", 32'(a_valid), 32'h0);
    tick();
    chk("rp_noack_v", 32'(a_valid), 32'h0);
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    chk("rp_v1",    32'(a_valid), 32'h1);
    chk("rp_pc",    a_pc,         32'h0);
    chk("rp_instr", a_instr,      32'hDEAD_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
